mc_ctrl_fsm: RTL

//  Multicycle control unit for the MIPS-style core; replaces single-cycle decode with a FETCH/DECODE/EXEC/MEM/WB FSM.

---
 rtl/mc_ctrl_fsm_pkg.sv | 46 ++++
 rtl/mc_ctrl_fsm_alu_dec.sv | 21 ++
 rtl/mc_ctrl_fsm.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_fsm_pkg.sv
// ---------------------------------------------------------------------------
// mc_ctrl_fsm_pkg : opcodes, FSM state encoding, pcSrc / aluOp codes.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mc_ctrl_fsm_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  localparam logic [5:0] OPC_R    = 6'b100000;
  localparam logic [5:0] OPC_BNE  = 6'b010000;
  localparam logic [5:0] OPC_BEQ  = 6'b010001;
  localparam logic [5:0] OPC_J    = 6'b010010;
  localparam logic [5:0] OPC_ADDI = 6'b000000;
  localparam logic [5:0] OPC_SW   = 6'b000001;
  localparam logic [5:0] OPC_LW   = 6'b000010;
  localparam logic [5:0] OPC_HALT = 6'b111111;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_RS  = 2'b10;
  localparam logic [1:0] PCSRC_JMP = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OPC_R, OPC_BNE, OPC_BEQ, OPC_J,
      OPC_ADDI, OPC_SW, OPC_LW, OPC_HALT: op_legal = 1'b1;
      default:                            op_legal = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_ctrl_fsm_alu_dec.sv
// ---------------------------------------------------------------------------
// mc_ctrl_fsm_alu_dec : R-type func -> {ALU op, jr flag}.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mc_ctrl_fsm_alu_dec #(
  parameter int FUNC_W = 6
) (
  input  logic [FUNC_W-1:0] func,
  output logic [2:0]        alu_op,
  output logic              is_jr
);

  // func 0..6 map straight onto ALU codes; everything above is jr
  assign alu_op = func[2:0];
  assign is_jr  = (func > FUNC_W'(6));

endmodule

`default_nettype wire

// File: rtl/mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// mc_ctrl_fsm : multicycle FETCH/DECODE/EXEC/MEM/WB controller, shared memory port.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int FUNC_W  = 6,
  parameter int ALUOP_W = 3,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    opcode,
  input  logic [FUNC_W-1:0]  func,
  input  logic               zeroflag,
  input  logic               mem_ready,
  output logic               irWrite,
  output logic               pcWrite,
  output logic               iorD,
  output logic               regWrite,
  output logic               memRead,
  output logic               memWrite,
  output logic               memToReg,
  output logic               aluSrc,
  output logic               regDst,
  output logic [1:0]         pcSrc,
  output logic [ALUOP_W-1:0] aluOp,
  output logic               halted,
  output logic               trap,
  output logic               trap_cause
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [FUNC_W-1:0]   func_q, func_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic                halted_q, halted_d;
  logic                trap_q, trap_d;
  logic                cause_q, cause_d;

  logic [5:0]          op6;
  logic [2:0]          dec_alu_op;
  logic                dec_is_jr;
  logic [2:0]          alu3;
  logic                timed_out;
  logic                taken;

  assign op6       = 6'(op_q);
  assign timed_out = (wait_cnt_q == CNT_LAST) && !mem_ready;

  mc_ctrl_fsm_alu_dec #(.FUNC_W(FUNC_W)) u_alu_dec (
    .func   (func_q),
    .alu_op (dec_alu_op),
    .is_jr  (dec_is_jr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_FETCH;
      op_q       <= '0;
      func_q     <= '0;
      wait_cnt_q <= '0;
      halted_q   <= 1'b0;
      trap_q     <= 1'b0;
      cause_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      func_q     <= func_d;
      wait_cnt_q <= wait_cnt_d;
      halted_q   <= halted_d;
      trap_q     <= trap_d;
      cause_q    <= cause_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    func_d     = func_q;
    wait_cnt_d = '0;
    halted_d   = halted_q;
    trap_d     = trap_q;
    cause_d    = cause_q;
    irWrite    = 1'b0;
    pcWrite    = 1'b0;
    iorD       = 1'b0;
    regWrite   = 1'b0;
    memRead    = 1'b0;
    memWrite   = 1'b0;
    memToReg   = 1'b1;
    aluSrc     = 1'b0;
    regDst     = 1'b1;
    pcSrc      = PCSRC_SEQ;
    alu3       = ALU_ADD;
    taken      = 1'b0;

    case (state_q)
      S_FETCH: begin
        memRead = 1'b1;
        if (mem_ready) begin
          irWrite = 1'b1;
          pcWrite = 1'b1;
          state_d = S_DECODE;
        end else if (timed_out) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      S_DECODE: begin
        op_d   = opcode;
        func_d = func;
        if (!op_legal(6'(opcode))) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = 1'b0;
        end else if (6'(opcode) == OPC_HALT) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        state_d = S_FETCH;
        case (op6)
          OPC_R: begin
            if (dec_is_jr) begin
              pcWrite = 1'b1;
              pcSrc   = PCSRC_RS;
            end else begin
              alu3    = dec_alu_op;
              state_d = S_WB;
            end
          end
          OPC_ADDI, OPC_LW, OPC_SW: begin
            aluSrc  = 1'b1;
            state_d = (op6 == OPC_ADDI) ? S_WB : S_MEM;
          end
          OPC_BEQ, OPC_BNE: begin
            alu3    = ALU_SUB;
            taken   = (op6 == OPC_BEQ) ? zeroflag : !zeroflag;
            pcWrite = taken;
            pcSrc   = taken ? PCSRC_BR : PCSRC_SEQ;
          end
          OPC_J: begin
            pcWrite = 1'b1;
            pcSrc   = PCSRC_JMP;
          end
          default: state_d = S_FETCH;
        endcase
      end

      S_MEM: begin
        // request is held every cycle until the memory acknowledges it
        iorD     = 1'b1;
        memRead  = (op6 == OPC_LW);
        memWrite = (op6 == OPC_SW);
        if (mem_ready) begin
          state_d = (op6 == OPC_LW) ? S_WB : S_FETCH;
        end else if (timed_out) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      S_WB: begin
        regWrite = 1'b1;
        if (op6 == OPC_LW) begin
          regDst   = 1'b0;
          memToReg = 1'b0;
        end else if (op6 == OPC_ADDI) begin
          regDst = 1'b0;
        end
        state_d = S_FETCH;
      end

      S_HALT, S_TRAP: state_d = state_q;

      default: state_d = S_FETCH;
    endcase
  end

  assign aluOp      = ALUOP_W'(alu3);
  assign halted     = halted_q;
  assign trap       = trap_q;
  assign trap_cause = cause_q;

endmodule

`default_nettype wire
